// File: rtl/cam_raw10_packer_pkg.sv
// Shared types, constants and the RAW10 packing helper for the camera packer.
package cam_pkg;

  localparam int RAW10_PIX_W  = 10;
  localparam int RAW10_WORD_W = 40;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } cam_state_t;

  typedef struct packed {
    logic                    eof;
    logic                    eol;
    logic                    sof;
    logic [RAW10_WORD_W-1:0] data;
  } cam_word_t;

  // CSI-2 RAW10 order: four MSB bytes (p0 in byte 0), then the LSB pairs as byte 4.
  function automatic logic [RAW10_WORD_W-1:0] pack_raw10(
    input logic [RAW10_PIX_W-1:0] p0,
    input logic [RAW10_PIX_W-1:0] p1,
    input logic [RAW10_PIX_W-1:0] p2,
    input logic [RAW10_PIX_W-1:0] p3
  );
    return {p3[1:0], p2[1:0], p1[1:0], p0[1:0],
            p3[9:2], p2[9:2], p1[9:2], p0[9:2]};
  endfunction

endpackage

// File: rtl/cam_word_fifo.sv
// Show-ahead FIFO of tagged RAW10 words; DEPTH must be a power of two (>= 2).
module cam_word_fifo
  import cam_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      wr_en,
  input  cam_word_t wr_data,
  input  logic      rd_en,
  output cam_word_t rd_data,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  cam_word_t   mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        wr_ok;
  logic        rd_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_ok   = rd_en && !empty;
  // A read in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (rd_ok) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/cam_raw10_packer.sv
// Camera pixel bus to tagged RAW10 words with line/frame geometry checks.
// Optional CAM_PACKER_STATS_EN adds last_line_pixels / last_frame_lines outputs.
//
// state    | meaning
// WAIT_SOF | idle, waiting for a frame_valid rising edge
// ACTIVE   | inside a frame, accepting pixels and closing lines
module cam_raw10_packer
  import cam_pkg::*;
#(
  parameter int WIDTH      = 1920,
  parameter int HEIGHT     = 1280,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_valid,
  input  logic                    line_valid,
  input  logic [RAW10_PIX_W-1:0]  pixel_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RAW10_WORD_W-1:0] out_data,
  output logic                    out_sof,
  output logic                    out_eol,
  output logic                    out_eof,
  output logic                    line_len_err,
  output logic                    frame_len_err,
  output logic                    overflow
`ifdef CAM_PACKER_STATS_EN
  ,
  output logic [15:0]             last_line_pixels,
  output logic [15:0]             last_frame_lines
`endif
);

  localparam logic [15:0]            WIDTH_C  = 16'(WIDTH);
  localparam logic [16:0]            HEIGHT_C = 17'(HEIGHT);
  localparam logic [RAW10_PIX_W-1:0] PIX_ZERO = '0;

  cam_state_t             state, state_nxt;
  logic                   fv_q, lv_q;
  logic [1:0]             slot;
  logic [RAW10_PIX_W-1:0] pix0, pix1, pix2;
  logic [15:0]            pix_cnt, line_cnt;
  logic [16:0]            lines_done;
  logic                   sof_pending;
  cam_word_t              stage_word, wr_word, head;
  logic                   stage_vld, wr_en;
  logic                   fifo_full, fifo_empty, rd_fire;
  logic                   frame_rise, frame_end, accept, line_end, last_line;

  assign frame_rise = (state == WAIT_SOF) && frame_valid && !fv_q;
  assign frame_end  = (state == ACTIVE) && fv_q && !frame_valid;
  assign accept     = (state == ACTIVE) && frame_valid && line_valid;
  // lv_q holds the qualified strobe, so a frame_valid fall mid-line also closes the line.
  assign line_end   = (state == ACTIVE) && lv_q && !(frame_valid && line_valid);
  assign last_line  = ({1'b0, line_cnt} + 17'd1) == HEIGHT_C;
  assign lines_done = {1'b0, line_cnt} + {16'd0, line_end};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_SOF;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_SOF: if (frame_valid && !fv_q) state_nxt = ACTIVE;
      ACTIVE:   if (fv_q && !frame_valid) state_nxt = WAIT_SOF;
      default:  state_nxt = WAIT_SOF;
    endcase
  end

  // fv_q resets high so a frame already running at reset release is not seen as a rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fv_q          <= 1'b1;
      lv_q          <= 1'b0;
      slot          <= 2'd0;
      pix0          <= '0;
      pix1          <= '0;
      pix2          <= '0;
      pix_cnt       <= '0;
      line_cnt      <= '0;
      sof_pending   <= 1'b0;
      stage_vld     <= 1'b0;
      stage_word    <= '0;
      line_len_err  <= 1'b0;
      frame_len_err <= 1'b0;
    end else begin
      fv_q          <= frame_valid;
      lv_q          <= frame_valid && line_valid;
      stage_vld     <= 1'b0;
      line_len_err  <= 1'b0;
      frame_len_err <= 1'b0;
      if (frame_rise) begin
        line_cnt    <= '0;
        pix_cnt     <= '0;
        slot        <= 2'd0;
        sof_pending <= 1'b1;
      end
      if (accept) begin
        slot <= slot + 2'd1;
        if (pix_cnt != 16'hFFFF) pix_cnt <= pix_cnt + 16'd1;
        case (slot)
          2'd0: pix0 <= pixel_data;
          2'd1: pix1 <= pixel_data;
          2'd2: pix2 <= pixel_data;
          default: begin
            stage_vld   <= 1'b1;
            stage_word  <= '{eof: 1'b0, eol: 1'b0, sof: sof_pending,
                             data: pack_raw10(pix0, pix1, pix2, pixel_data)};
            sof_pending <= 1'b0;
          end
        endcase
      end
      if (line_end) begin
        slot         <= 2'd0;
        pix_cnt      <= '0;
        line_len_err <= (pix_cnt != WIDTH_C);
        if (line_cnt != 16'hFFFF) line_cnt <= line_cnt + 16'd1;
        if (slot != 2'd0) sof_pending <= 1'b0;
      end
      if (frame_end) frame_len_err <= (lines_done != HEIGHT_C);
    end
  end

  // A staged full group is written one edge late so a coinciding line end can tag it.
  always_comb begin
    wr_en   = 1'b0;
    wr_word = '0;
    if (stage_vld) begin
      wr_en       = 1'b1;
      wr_word     = stage_word;
      wr_word.eol = line_end;
      wr_word.eof = line_end && last_line;
    end else if (line_end && (slot != 2'd0)) begin
      wr_en        = 1'b1;
      wr_word.sof  = sof_pending;
      wr_word.eol  = 1'b1;
      wr_word.eof  = last_line;
      wr_word.data = pack_raw10(pix0,
                                (slot >= 2'd2) ? pix1 : PIX_ZERO,
                                (slot == 2'd3) ? pix2 : PIX_ZERO,
                                PIX_ZERO);
    end
  end

  cam_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_word),
    .rd_en   (out_ready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign rd_fire   = out_valid && out_ready;
  assign {out_eof, out_eol, out_sof, out_data} = fifo_empty ? cam_word_t'('0) : head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      overflow <= 1'b0;
    else if (wr_en && fifo_full && !rd_fire)      overflow <= 1'b1;
  end

`ifdef CAM_PACKER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_line_pixels <= '0;
      last_frame_lines <= '0;
    end else begin
      if (line_end)  last_line_pixels <= pix_cnt;
      if (frame_end) last_frame_lines <= lines_done[16] ? 16'hFFFF : lines_done[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_cam_raw10_packer.sv
// Randomized self-checking bench for cam_raw10_packer (WIDTH=8, HEIGHT=2, FIFO_DEPTH=4).
module tb_cam_raw10_packer;

  localparam int W = 8;
  localparam int H = 2;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_valid = 1'b0;
  logic        line_valid = 1'b0;
  logic [9:0]  pixel_data = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [39:0] out_data;
  logic        out_sof, out_eol, out_eof;
  logic        line_len_err, frame_len_err, overflow;
`ifdef CAM_PACKER_STATS_EN
  logic [15:0] last_line_pixels, last_frame_lines;
`endif

  cam_raw10_packer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_valid   (frame_valid),
    .line_valid    (line_valid),
    .pixel_data    (pixel_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_sof       (out_sof),
    .out_eol       (out_eol),
    .out_eof       (out_eof),
    .line_len_err  (line_len_err),
    .frame_len_err (frame_len_err),
    .overflow      (overflow)
`ifdef CAM_PACKER_STATS_EN
    ,
    .last_line_pixels (last_line_pixels),
    .last_frame_lines (last_frame_lines)
`endif
  );

  always #5 clk = ~clk;

  logic [42:0] exp_q[$];
  logic [42:0] got_q[$];
  logic [9:0]  line_px[$];
  logic [9:0]  fixed_q[$];
  int          line_len[8];
  int          n_lines;
  bit          end_with_fv;
  int          bp_mode;      // 0: always ready, 1: random (never two lows in a row), 2: stalled
  bit          ready_was_low = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          lerr_cnt = 0, ferr_cnt = 0;
  int          got_base, lerr_base, ferr_base, exp_lerr, exp_ferr;

  // Monitor: records every accepted word and counts error pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) got_q.push_back({out_eof, out_eol, out_sof, out_data});
      if (line_len_err)  lerr_cnt++;
      if (frame_len_err) ferr_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ready_was_low ? 1'b1 : ($urandom_range(0, 2) != 0);
      default: out_ready = 1'b0;
    endcase
    ready_was_low = !out_ready;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    fixed_q.delete();
    got_base  = got_q.size();
    lerr_base = lerr_cnt;
    ferr_base = ferr_cnt;
    exp_lerr  = 0;
    exp_ferr  = 0;
    end_with_fv = 1'b0;
  endtask

  // Reference: chunk a line into groups of four, zero-pad the tail, tag sof/eol/eof.
  task automatic model_line(input int idx, input bit first);
    int n, v;
    logic [63:0] d;
    logic eol, eof, sof;
    n = line_px.size();
    for (int g = 0; g < n; g += 4) begin
      d = '0;
      for (int k = 0; k < 4; k++) begin
        v = (g + k < n) ? int'(line_px[g+k]) : 0;
        d = d + (64'(v / 4) << (8 * k)) + (64'(v % 4) << (32 + 2 * k));
      end
      sof = first && (g == 0);
      eol = (g + 4 >= n);
      eof = eol && (idx == H - 1);
      exp_q.push_back({eof, eol, sof, d[39:0]});
    end
  endtask

  task automatic drive_frame();
    frame_valid = 1'b1;
    tick();
    tick();
    for (int l = 0; l < n_lines; l++) begin
      line_px.delete();
      for (int i = 0; i < line_len[l]; i++)
        line_px.push_back(fixed_q.size() > 0 ? fixed_q.pop_front() : 10'($urandom_range(0, 1023)));
      model_line(l, l == 0);
      if (line_len[l] != W) exp_lerr++;
      line_valid = 1'b1;
      foreach (line_px[i]) begin
        pixel_data = line_px[i];
        tick();
      end
      if (!(end_with_fv && l == n_lines - 1)) begin
        line_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    line_valid  = 1'b0;
    frame_valid = 1'b0;
    pixel_data  = '0;
    if (n_lines != H) exp_ferr++;
    repeat (3) tick();
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while ((got_q.size() - got_base) < exp_q.size() && c < budget) begin
      tick();
      c++;
    end
    repeat (2) tick();
  endtask

  task automatic test_reset();
    bp_mode = 0;
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if ({out_eof, out_eol, out_sof, out_data} !== 43'd0) $display("FAIL rst_word: got %h expected 0", {out_eof, out_eol, out_sof, out_data}); else n_pass++;
    n_checks++; if ({line_len_err, frame_len_err, overflow} !== 3'b000) $display("FAIL rst_flags: got %b expected 000", {line_len_err, frame_len_err, overflow}); else n_pass++;
    rst = 1'b0;
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL post_rst_valid: got %b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_basic();
    clear_sb();
    bp_mode = 0;
    fixed_q.push_back(10'h3FF); fixed_q.push_back(10'h001);
    fixed_q.push_back(10'h155); fixed_q.push_back(10'h2AA);
    n_lines = 2; line_len[0] = 8; line_len[1] = 8;
    drive_frame();
    drain(100);
    n_checks++; if (got_q.size() - got_base !== exp_q.size()) $display("FAIL basic_count: got %0d expected %0d", got_q.size() - got_base, exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[got_base+i] !== exp_q[i]) $display("FAIL basic_word%0d: got %h expected %h", i, got_q[got_base+i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (lerr_cnt - lerr_base !== exp_lerr) $display("FAIL basic_lerr: got %0d expected %0d", lerr_cnt - lerr_base, exp_lerr); else n_pass++;
    n_checks++; if (ferr_cnt - ferr_base !== exp_ferr) $display("FAIL basic_ferr: got %0d expected %0d", ferr_cnt - ferr_base, exp_ferr); else n_pass++;
`ifdef CAM_PACKER_STATS_EN
    n_checks++; if (last_line_pixels !== 16'(W)) $display("FAIL stats_pixels: got %0d expected %0d", last_line_pixels, W); else n_pass++;
    n_checks++; if (last_frame_lines !== 16'(H)) $display("FAIL stats_lines: got %0d expected %0d", last_frame_lines, H); else n_pass++;
`endif
  endtask

  task automatic test_geometry(input string name, input int nl, input int l0, input int l1,
                               input int l2, input bit fv_end, input int bp);
    clear_sb();
    bp_mode = bp;
    n_lines = nl; line_len[0] = l0; line_len[1] = l1; line_len[2] = l2;
    end_with_fv = fv_end;
    drive_frame();
    drain(200);
    n_checks++; if (got_q.size() - got_base !== exp_q.size()) $display("FAIL %s_count: got %0d expected %0d", name, got_q.size() - got_base, exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[got_base+i] !== exp_q[i]) $display("FAIL %s_word%0d: got %h expected %h", name, i, got_q[got_base+i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (lerr_cnt - lerr_base !== exp_lerr) $display("FAIL %s_lerr: got %0d expected %0d", name, lerr_cnt - lerr_base, exp_lerr); else n_pass++;
    n_checks++; if (ferr_cnt - ferr_base !== exp_ferr) $display("FAIL %s_ferr: got %0d expected %0d", name, ferr_cnt - ferr_base, exp_ferr); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL %s_overflow: got %b expected 0", name, overflow); else n_pass++;
  endtask

  task automatic test_short_line();
    test_geometry("short_line", 2, 6, 8, 0, 1'b1, 0);
  endtask

  task automatic test_long_frame();
    test_geometry("long_frame", 3, 8, 8, 8, 1'b0, 1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++)
      test_geometry($sformatf("rand%0d", it), $urandom_range(1, 3), $urandom_range(1, 12),
                    $urandom_range(1, 12), $urandom_range(1, 12), 1'($urandom_range(0, 1)), 1);
  endtask

  task automatic test_overflow();
    clear_sb();
    bp_mode = 2;
    n_lines = 3; line_len[0] = 8; line_len[1] = 8; line_len[2] = 8;
    drive_frame();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL ovf_valid: got %b expected 1", out_valid); else n_pass++;
    n_checks++; if ({out_eof, out_eol, out_sof, out_data} !== exp_q[0]) $display("FAIL ovf_head_stable: got %h expected %h", {out_eof, out_eol, out_sof, out_data}, exp_q[0]); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", overflow); else n_pass++;
    n_checks++; if (ferr_cnt - ferr_base !== exp_ferr) $display("FAIL ovf_ferr: got %0d expected %0d", ferr_cnt - ferr_base, exp_ferr); else n_pass++;
    bp_mode = 0;
    repeat (15) tick();
    n_checks++; if (got_q.size() - got_base !== D) $display("FAIL ovf_drain_count: got %0d expected %0d", got_q.size() - got_base, D); else n_pass++;
    for (int i = 0; i < D && got_base + i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[got_base+i] !== exp_q[i]) $display("FAIL ovf_word%0d: got %h expected %h", i, got_q[got_base+i], exp_q[i]); else n_pass++;
    end
    rst = 1'b1;
    #1;
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_cleared: got %b expected 0", overflow); else n_pass++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset_midframe();
    clear_sb();
    bp_mode = 0;
    frame_valid = 1'b1;
    tick();
    tick();
    line_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pixel_data = 10'($urandom_range(0, 1023));
      tick();
    end
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", out_valid); else n_pass++;
    got_base  = got_q.size();
    lerr_base = lerr_cnt;
    ferr_base = ferr_cnt;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pixel_data = 10'($urandom_range(0, 1023));
      tick();
    end
    line_valid = 1'b0;
    tick();
    line_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pixel_data = 10'($urandom_range(0, 1023));
      tick();
    end
    line_valid  = 1'b0;
    tick();
    frame_valid = 1'b0;
    repeat (8) tick();
    n_checks++; if (got_q.size() - got_base !== 0) $display("FAIL midrst_no_words: got %0d expected 0", got_q.size() - got_base); else n_pass++;
    n_checks++; if ((lerr_cnt - lerr_base) + (ferr_cnt - ferr_base) !== 0) $display("FAIL midrst_no_errs: got %0d expected 0", (lerr_cnt - lerr_base) + (ferr_cnt - ferr_base)); else n_pass++;
    test_geometry("after_rst", 2, 8, 8, 0, 1'b0, 0);
    n_checks++; if (got_q.size() <= got_base || got_q[got_base][40] !== 1'b1) $display("FAIL after_rst_sof: got %0d words, first sof not 1 expected 1", got_q.size() - got_base); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_line();
    test_long_frame();
    test_random();
    test_overflow();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
